// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
// Shared types and constants for the RV32 core memory stage.
//   XLEN         data / address width (only 32 is supported)
//   datatype_e   load/store width encoding taken straight from funct3
//   lsu_state_e  states of the memory-stage handshake FSM
//   rep_byte     replicate a byte into all four byte lanes
//   rep_half     replicate a halfword into both halfword lanes
// ----------------------------------------------------------------------------
package core_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      DT_B  = 3'b000,
      DT_H  = 3'b001,
      DT_W  = 3'b010,
      DT_BU = 3'b100,
      DT_HU = 3'b101
   } datatype_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } lsu_state_e;

   function automatic logic [31:0] rep_byte(input logic [7:0] b);
      return {4{b}};
   endfunction

   function automatic logic [31:0] rep_half(input logic [15:0] h);
      return {2{h}};
   endfunction

endpackage

// File: rtl/lsu_align.sv
// ----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane steering for the memory stage.
// Store side: byte strobes and lane-replicated write data.
// Load side : lane selection from the returned word plus sign/zero extension.
// Ports:
//   addr_lsb_i    low two bits of the effective address
//   datatype_i    funct3 width code (see core_pkg::datatype_e)
//   store_data_i  raw rs2/frs2 value
//   load_word_i   full word returned by data memory
//   wstrb_o       byte strobes for a store of this width/offset
//   wdata_o       store data replicated into every lane it may land in
//   load_data_o   extracted and extended load value
// ----------------------------------------------------------------------------
module lsu_align
   import core_pkg::*;
(
   input  logic [1:0]  addr_lsb_i,
   input  logic [2:0]  datatype_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] load_word_i,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o,
   output logic [31:0] load_data_o
);

   datatype_e   dt_s;
   logic [31:0] byte_shift_s;
   logic [31:0] half_shift_s;
   logic [7:0]  byte_s;
   logic [15:0] half_s;

   assign dt_s = datatype_e'(datatype_i);

   // Bring the addressed byte / halfword down to bit 0. Halfwords ignore
   // addr[0] and words ignore both low bits, so no misalignment handling.
   assign byte_shift_s = load_word_i >> {addr_lsb_i, 3'b000};
   assign half_shift_s = load_word_i >> {addr_lsb_i[1], 4'b0000};
   assign byte_s       = byte_shift_s[7:0];
   assign half_s       = half_shift_s[15:0];

   // Store strobes and lane replication
   always_comb begin
      wstrb_o = 4'b0000;
      wdata_o = store_data_i;
      case (dt_s)
         DT_B, DT_BU: begin
            wstrb_o = 4'b0001 << addr_lsb_i;
            wdata_o = rep_byte(store_data_i[7:0]);
         end
         DT_H, DT_HU: begin
            wstrb_o = addr_lsb_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = rep_half(store_data_i[15:0]);
         end
         DT_W: begin
            wstrb_o = 4'b1111;
            wdata_o = store_data_i;
         end
         default: begin
            // Undefined width code: write nothing.
            wstrb_o = 4'b0000;
            wdata_o = store_data_i;
         end
      endcase
   end

   // Load lane extraction and extension
   always_comb begin
      load_data_o = load_word_i;
      case (dt_s)
         DT_B:    load_data_o = {{24{byte_s[7]}}, byte_s};
         DT_H:    load_data_o = {{16{half_s[15]}}, half_s};
         DT_BU:   load_data_o = {24'h000000, byte_s};
         DT_HU:   load_data_o = {16'h0000, half_s};
         DT_W:    load_data_o = load_word_i;
         default: load_data_o = load_word_i;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// ----------------------------------------------------------------------------
// mem_stage_lsu
// MEM stage of the 5-stage RV32 pipeline. Runs the req/ready + rvalid
// handshake with data memory for loads and stores, freezes the front of the
// pipeline until the access completes and registers the MEM/WB state.
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   ex_*                EX/MEM register contents (address, store data, ctrl)
//   stall_in            global stall from another stage
//   dm_req/dm_ready     request handshake to data memory
//   dm_addr             word-aligned address
//   dm_wstrb/dm_wdata   byte strobes (0 for loads) and lane-aligned data
//   dm_rvalid/dm_rdata  response (load word or write ack)
//   mem_stall           freeze IF..EX/MEM while an access is in flight
//   wb_*                MEM/WB register outputs
// ----------------------------------------------------------------------------
module mem_stage_lsu #(
   parameter int XLEN = core_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] ex_aludata,
   input  logic [XLEN-1:0] ex_storedata,
   input  logic            ex_memread,
   input  logic            ex_memwrite,
   input  logic            ex_memtoreg,
   input  logic [4:0]      ex_rd,
   input  logic            ex_regwrite,
   input  logic            ex_floatwb,
   input  logic [2:0]      ex_datatype,
   input  logic            stall_in,
   output logic            dm_req,
   input  logic            dm_ready,
   output logic [XLEN-1:0] dm_addr,
   output logic [3:0]      dm_wstrb,
   output logic [XLEN-1:0] dm_wdata,
   input  logic            dm_rvalid,
   input  logic [XLEN-1:0] dm_rdata,
   output logic            mem_stall,
   output logic [XLEN-1:0] wb_aludata,
   output logic [XLEN-1:0] wb_loaddata,
   output logic            wb_memtoreg,
   output logic [4:0]      wb_rd,
   output logic            wb_regwrite,
   output logic            wb_floatwb
);

   import core_pkg::*;

   logic            op_s;
   logic            is_store_s;
   logic [3:0]      strb_s;
   logic [XLEN-1:0] wdata_s;
   logic [XLEN-1:0] load_ext_s;

   lsu_state_e      state_q;
   logic [XLEN-1:0] hold_q;

   logic [XLEN-1:0] wb_aludata_q,  wb_aludata_d;
   logic [XLEN-1:0] wb_loaddata_q, wb_loaddata_d;
   logic            wb_memtoreg_q, wb_memtoreg_d;
   logic [4:0]      wb_rd_q,       wb_rd_d;
   logic            wb_regwrite_q, wb_regwrite_d;
   logic            wb_floatwb_q,  wb_floatwb_d;

   // A simultaneous read+write request is handled as a load.
   assign op_s       = ex_memread | ex_memwrite;
   assign is_store_s = ex_memwrite & ~ex_memread;

   lsu_align u_align (
      .addr_lsb_i   (ex_aludata[1:0]),
      .datatype_i   (ex_datatype),
      .store_data_i (ex_storedata),
      .load_word_i  (dm_rdata),
      .wstrb_o      (strb_s),
      .wdata_o      (wdata_s),
      .load_data_o  (load_ext_s)
   );

   // The EX/MEM register is frozen by mem_stall, so address, strobes and
   // data stay stable for as long as the request is outstanding.
   assign dm_addr  = {ex_aludata[XLEN-1:2], 2'b00};
   assign dm_wstrb = is_store_s ? strb_s : 4'b0000;
   assign dm_wdata = wdata_s;

   // Request goes out in the same cycle the op shows up in IDLE; REQ keeps
   // it asserted until memory accepts.
   assign dm_req    = ((state_q == IDLE) & op_s) | (state_q == REQ);
   assign mem_stall = op_s & (state_q != DONE);

   // Handshake FSM and response holding register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         hold_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (op_s) begin
                  state_q <= dm_ready ? WAIT : REQ;
               end else begin
                  state_q <= IDLE;
               end
            end
            REQ: begin
               if (dm_ready) begin
                  state_q <= WAIT;
               end else begin
                  state_q <= REQ;
               end
            end
            WAIT: begin
               // stall_in deliberately has no say here: the response is
               // captured now and DONE absorbs the global stall.
               if (dm_rvalid) begin
                  state_q <= DONE;
                  hold_q  <= load_ext_s;
               end else begin
                  state_q <= WAIT;
               end
            end
            DONE: begin
               // Parked until the pipeline moves; never reissues.
               if (!stall_in) begin
                  state_q <= IDLE;
               end else begin
                  state_q <= DONE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // MEM/WB next state: global stall holds, own stall bubbles, else capture
   always_comb begin
      wb_aludata_d  = wb_aludata_q;
      wb_loaddata_d = wb_loaddata_q;
      wb_memtoreg_d = wb_memtoreg_q;
      wb_rd_d       = wb_rd_q;
      wb_regwrite_d = wb_regwrite_q;
      wb_floatwb_d  = wb_floatwb_q;
      if (stall_in) begin
         wb_regwrite_d = wb_regwrite_q;
         wb_floatwb_d  = wb_floatwb_q;
      end else if (mem_stall) begin
         // Bubble: kill the register writes, leave the payload as is.
         wb_regwrite_d = 1'b0;
         wb_floatwb_d  = 1'b0;
      end else begin
         wb_aludata_d  = ex_aludata;
         wb_memtoreg_d = ex_memtoreg;
         wb_rd_d       = ex_rd;
         wb_regwrite_d = ex_regwrite;
         wb_floatwb_d  = ex_floatwb;
         if (op_s) begin
            wb_loaddata_d = hold_q;
         end else begin
            wb_loaddata_d = wb_loaddata_q;
         end
      end
   end

   // MEM/WB register
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_aludata_q  <= '0;
         wb_loaddata_q <= '0;
         wb_memtoreg_q <= 1'b0;
         wb_rd_q       <= 5'd0;
         wb_regwrite_q <= 1'b0;
         wb_floatwb_q  <= 1'b0;
      end else begin
         wb_aludata_q  <= wb_aludata_d;
         wb_loaddata_q <= wb_loaddata_d;
         wb_memtoreg_q <= wb_memtoreg_d;
         wb_rd_q       <= wb_rd_d;
         wb_regwrite_q <= wb_regwrite_d;
         wb_floatwb_q  <= wb_floatwb_d;
      end
   end

   assign wb_aludata  = wb_aludata_q;
   assign wb_loaddata = wb_loaddata_q;
   assign wb_memtoreg = wb_memtoreg_q;
   assign wb_rd       = wb_rd_q;
   assign wb_regwrite = wb_regwrite_q;
   assign wb_floatwb  = wb_floatwb_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// ----------------------------------------------------------------------------
// tb_mem_stage_lsu
// Directed scenarios plus a randomized run against a word-array memory model.
// Inputs change 1 time unit after the rising edge and outputs are sampled a
// further unit later, well away from the active edge.
// ----------------------------------------------------------------------------
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ex_aludata, ex_storedata;
   logic        ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_floatwb;
   logic [4:0]  ex_rd;
   logic [2:0]  ex_datatype;
   logic        stall_in;
   logic        dm_req, dm_ready, dm_rvalid;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic [3:0]  dm_wstrb;
   logic        mem_stall;
   logic [31:0] wb_aludata, wb_loaddata;
   logic        wb_memtoreg, wb_regwrite, wb_floatwb;
   logic [4:0]  wb_rd;

   always #5 clk = ~clk;

   mem_stage_lsu dut (
      .clk(clk), .rst(rst),
      .ex_aludata(ex_aludata), .ex_storedata(ex_storedata),
      .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_memtoreg(ex_memtoreg), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_floatwb(ex_floatwb),
      .ex_datatype(ex_datatype), .stall_in(stall_in),
      .dm_req(dm_req), .dm_ready(dm_ready), .dm_addr(dm_addr),
      .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata),
      .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_stall(mem_stall),
      .wb_aludata(wb_aludata), .wb_loaddata(wb_loaddata),
      .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd),
      .wb_regwrite(wb_regwrite), .wb_floatwb(wb_floatwb)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model of the MEM/WB payload as of the last capture.
   logic [31:0] m_aludata, m_loaddata;
   logic [4:0]  m_rd;
   logic        m_memtoreg;
   bit          m_ld_known;

   // Observations gathered while an access is in flight.
   int          obs_req, obs_stall, obs_unstable, obs_bubble, obs_hold;
   logic        obs_first_req;
   logic [31:0] obs_addr, obs_wdata;
   logic [3:0]  obs_strb;

   logic [31:0] mem [16];

   // ---------------- reference functions (arithmetic form) ----------------
   function automatic logic [31:0] exp_load(input logic [2:0] dt, input logic [1:0] off,
                                            input logic [31:0] w);
      longint unsigned wv, b, h;
      wv = w;
      b  = (wv >> (8 * off)) % 256;
      h  = (wv >> (16 * off[1])) % 65536;
      case (dt)
         3'b000:  return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
         3'b001:  return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
         3'b100:  return 32'(b);
         3'b101:  return 32'(h);
         default: return w;
      endcase
   endfunction

   function automatic logic [3:0] exp_strb(input logic [2:0] dt, input logic [1:0] off);
      case (dt)
         3'b000:  return 4'(1 << off);
         3'b001:  return (off >= 2) ? 4'b1100 : 4'b0011;
         3'b010:  return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] dt, input logic [31:0] sd);
      case (dt)
         3'b000:  return 32'((sd % 256) * 32'h0101_0101);
         3'b001:  return 32'((sd % 65536) * 32'h0001_0001);
         default: return sd;
      endcase
   endfunction

   // ---------------- stimulus helpers (no pass/fail decisions) ------------
   task automatic observe_cycle();
      if (dm_req === 1'b1) obs_req++;
      if (mem_stall === 1'b1) obs_stall++;
   endtask

   task automatic observe_held();
      if (wb_regwrite !== 1'b0 || wb_floatwb !== 1'b0) obs_bubble++;
      if (wb_aludata !== m_aludata || wb_rd !== m_rd || wb_memtoreg !== m_memtoreg ||
          (m_ld_known && wb_loaddata !== m_loaddata)) obs_hold++;
   endtask

   task automatic commit_model(input bit known, input logic [31:0] ld);
      m_aludata  = ex_aludata;
      m_rd       = ex_rd;
      m_memtoreg = ex_memtoreg;
      m_ld_known = known;
      if (known) m_loaddata = ld;
   endtask

   // Plays the memory side of one access whose ex_* fields are already set.
   task automatic run_handshake(input int rdy_dly, input int rv_dly, input bit stall_rv,
                                input int done_stall, input logic [31:0] rdata);
      obs_req = 0; obs_stall = 0; obs_unstable = 0; obs_bubble = 0; obs_hold = 0;
      stall_in  = 1'b0;
      dm_rvalid = 1'b0;
      for (int c = 0; c <= rdy_dly; c++) begin
         dm_ready = (c == rdy_dly);
         #1;
         if (c == 0) begin
            obs_addr = dm_addr; obs_strb = dm_wstrb; obs_wdata = dm_wdata;
            obs_first_req = dm_req;
         end else if (dm_addr !== obs_addr || dm_wstrb !== obs_strb || dm_wdata !== obs_wdata) begin
            obs_unstable++;
         end
         observe_cycle();
         @(posedge clk); #1;
         observe_held();
      end
      dm_ready = 1'b0;
      for (int c = 0; c <= rv_dly; c++) begin
         dm_rvalid = (c == rv_dly);
         dm_rdata  = (c == rv_dly) ? rdata : $urandom();
         stall_in  = (c == rv_dly) ? stall_rv : 1'b0;
         #1;
         observe_cycle();
         @(posedge clk); #1;
         observe_held();
      end
      dm_rvalid = 1'b0;
      dm_rdata  = $urandom();
      for (int c = 0; c < done_stall; c++) begin
         stall_in = 1'b1;
         #1;
         observe_cycle();
         @(posedge clk); #1;
         observe_held();
      end
      stall_in = 1'b0;
      #1;
      observe_cycle();
      @(posedge clk); #1;
      ex_memread  = 1'b0;
      ex_memwrite = 1'b0;
   endtask

   task automatic set_ex(input logic rd_en, input logic wr_en, input logic [2:0] dt,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                         input logic rw, input logic m2r, input logic fwb);
      ex_memread = rd_en; ex_memwrite = wr_en; ex_datatype = dt;
      ex_aludata = addr; ex_storedata = sd; ex_rd = rd;
      ex_regwrite = rw; ex_memtoreg = m2r; ex_floatwb = fwb;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      set_ex(1'b0, 1'b0, 3'($urandom()), $urandom(), $urandom(), 5'($urandom()), 1'b1, 1'b1, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (wb_aludata !== 32'h0) $display("FAIL reset_wb_aludata got %h want 0", wb_aludata); else n_pass++;
      n_checks++; if (wb_loaddata !== 32'h0) $display("FAIL reset_wb_loaddata got %h want 0", wb_loaddata); else n_pass++;
      n_checks++; if (wb_rd !== 5'd0) $display("FAIL reset_wb_rd got %0d want 0", wb_rd); else n_pass++;
      n_checks++; if ({wb_memtoreg, wb_regwrite, wb_floatwb} !== 3'b000)
         $display("FAIL reset_wb_ctrl got %b want 000", {wb_memtoreg, wb_regwrite, wb_floatwb}); else n_pass++;
      n_checks++; if (dm_req !== 1'b0) $display("FAIL reset_dm_req got %b want 0", dm_req); else n_pass++;
      n_checks++; if (mem_stall !== 1'b0) $display("FAIL reset_mem_stall got %b want 0", mem_stall); else n_pass++;
      set_ex(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      m_aludata = 32'h0; m_loaddata = 32'h0; m_rd = 5'd0; m_memtoreg = 1'b0; m_ld_known = 1'b1;
   endtask

   task automatic test_lb_sign();
      set_ex(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
      run_handshake(0, 0, 1'b0, 0, 32'h80FF_0000);
      n_checks++; if (obs_addr !== 32'h0000_1000) $display("FAIL lb_addr got %h want 00001000", obs_addr); else n_pass++;
      n_checks++; if (obs_strb !== 4'b0000) $display("FAIL lb_wstrb got %b want 0000", obs_strb); else n_pass++;
      n_checks++; if (obs_stall !== 2) $display("FAIL lb_stall_cycles got %0d want 2", obs_stall); else n_pass++;
      n_checks++; if (obs_req !== 1) $display("FAIL lb_req_cycles got %0d want 1", obs_req); else n_pass++;
      n_checks++; if (wb_loaddata !== 32'hFFFF_FF80) $display("FAIL lb_loaddata got %h want ffffff80", wb_loaddata); else n_pass++;
      n_checks++; if ({wb_regwrite, wb_memtoreg} !== 2'b11) $display("FAIL lb_wb_ctrl got %b want 11", {wb_regwrite, wb_memtoreg}); else n_pass++;
      n_checks++; if (wb_rd !== 5'd7) $display("FAIL lb_wb_rd got %0d want 7", wb_rd); else n_pass++;
      commit_model(1'b1, 32'hFFFF_FF80);
   endtask

   task automatic test_sh_bubble();
      set_ex(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 5'd3, 1'b1, 1'b0, 1'b0);
      run_handshake(3, 0, 1'b0, 0, $urandom());
      n_checks++; if (obs_req !== 4) $display("FAIL sh_req_cycles got %0d want 4", obs_req); else n_pass++;
      n_checks++; if (obs_strb !== 4'b1100) $display("FAIL sh_wstrb got %b want 1100", obs_strb); else n_pass++;
      n_checks++; if (obs_wdata !== 32'hBEEF_BEEF) $display("FAIL sh_wdata got %h want beefbeef", obs_wdata); else n_pass++;
      n_checks++; if (obs_unstable !== 0) $display("FAIL sh_req_stable got %0d changes want 0", obs_unstable); else n_pass++;
      n_checks++; if (obs_bubble !== 0) $display("FAIL sh_bubble got %0d writes want 0", obs_bubble); else n_pass++;
      n_checks++; if (obs_hold !== 0) $display("FAIL sh_payload_hold got %0d changes want 0", obs_hold); else n_pass++;
      n_checks++; if (obs_stall !== 5) $display("FAIL sh_stall_cycles got %0d want 5", obs_stall); else n_pass++;
      n_checks++; if (wb_regwrite !== 1'b1) $display("FAIL sh_wb_regwrite got %b want 1", wb_regwrite); else n_pass++;
      commit_model(1'b0, 32'h0);
   endtask

   task automatic test_lhu_lw();
      logic [31:0] r;
      set_ex(1'b1, 1'b0, 3'b101, 32'h0000_0010, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0);
      run_handshake(1, 2, 1'b0, 0, 32'h1234_8001);
      n_checks++; if (wb_loaddata !== 32'h0000_8001) $display("FAIL lhu_loaddata got %h want 00008001", wb_loaddata); else n_pass++;
      n_checks++; if (obs_stall !== 5) $display("FAIL lhu_stall_cycles got %0d want 5", obs_stall); else n_pass++;
      commit_model(1'b1, 32'h0000_8001);
      r = $urandom();
      set_ex(1'b1, 1'b0, 3'b010, 32'h0000_0024, 32'h0, 5'd2, 1'b0, 1'b1, 1'b1);
      run_handshake(0, 1, 1'b0, 0, r);
      n_checks++; if (wb_loaddata !== r) $display("FAIL lw_loaddata got %h want %h", wb_loaddata, r); else n_pass++;
      n_checks++; if ({wb_floatwb, wb_regwrite, wb_memtoreg} !== 3'b101)
         $display("FAIL lw_wb_ctrl got %b want 101", {wb_floatwb, wb_regwrite, wb_memtoreg}); else n_pass++;
      commit_model(1'b1, r);
   endtask

   task automatic test_stall_in_wait();
      set_ex(1'b1, 1'b0, 3'b001, 32'h0000_0006, 32'h0, 5'd13, 1'b1, 1'b1, 1'b0);
      run_handshake(0, 1, 1'b1, 3, 32'h8001_0000);
      n_checks++; if (obs_req !== 1) $display("FAIL stallwait_req_cycles got %0d want 1", obs_req); else n_pass++;
      n_checks++; if (obs_stall !== 3) $display("FAIL stallwait_stall_cycles got %0d want 3", obs_stall); else n_pass++;
      n_checks++; if (obs_hold !== 0) $display("FAIL stallwait_wb_hold got %0d changes want 0", obs_hold); else n_pass++;
      n_checks++; if (obs_bubble !== 0) $display("FAIL stallwait_bubble got %0d writes want 0", obs_bubble); else n_pass++;
      n_checks++; if (wb_loaddata !== 32'hFFFF_8001) $display("FAIL stallwait_loaddata got %h want ffff8001", wb_loaddata); else n_pass++;
      n_checks++; if (wb_rd !== 5'd13) $display("FAIL stallwait_wb_rd got %0d want 13", wb_rd); else n_pass++;
      commit_model(1'b1, 32'hFFFF_8001);
   endtask

   task automatic test_reset_mid_op();
      set_ex(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
      dm_ready = 1'b1; stall_in = 1'b0; dm_rvalid = 1'b0;
      #1;
      n_checks++; if (dm_req !== 1'b1) $display("FAIL rstmid_issue got %b want 1", dm_req); else n_pass++;
      @(posedge clk); #1;
      dm_ready = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      set_ex(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      dm_rvalid = 1'b1; dm_rdata = 32'hA5A5_A5A5;
      #1;
      n_checks++; if ({wb_aludata, wb_loaddata} !== 64'h0) $display("FAIL rstmid_wb_data got %h %h want 0 0", wb_aludata, wb_loaddata); else n_pass++;
      n_checks++; if ({wb_rd, wb_memtoreg, wb_regwrite, wb_floatwb} !== 8'h00)
         $display("FAIL rstmid_wb_ctrl got %h want 00", {wb_rd, wb_memtoreg, wb_regwrite, wb_floatwb}); else n_pass++;
      n_checks++; if ({dm_req, mem_stall} !== 2'b00) $display("FAIL rstmid_idle got %b want 00", {dm_req, mem_stall}); else n_pass++;
      @(posedge clk); #1;
      dm_rvalid = 1'b0;
      n_checks++; if (wb_loaddata !== 32'h0) $display("FAIL rstmid_stale_rvalid got %h want 0", wb_loaddata); else n_pass++;
      m_aludata = 32'h0; m_loaddata = 32'h0; m_rd = 5'd0; m_memtoreg = 1'b0; m_ld_known = 1'b1;
      set_ex(1'b1, 1'b0, 3'b000, 32'h0000_0041, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0);
      run_handshake(0, 0, 1'b0, 0, 32'h0000_7F00);
      n_checks++; if (obs_stall !== 2) $display("FAIL rstmid_next_stall got %0d want 2", obs_stall); else n_pass++;
      n_checks++; if (wb_loaddata !== 32'h0000_007F) $display("FAIL rstmid_next_loaddata got %h want 0000007f", wb_loaddata); else n_pass++;
      commit_model(1'b1, 32'h0000_007F);
   endtask

   task automatic test_alu_op();
      set_ex(1'b0, 1'b0, 3'b010, 32'hDEAD_BEEF, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
      #1;
      n_checks++; if ({dm_req, mem_stall} !== 2'b00) $display("FAIL alu_no_req got %b want 00", {dm_req, mem_stall}); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (wb_aludata !== 32'hDEAD_BEEF) $display("FAIL alu_wb_aludata got %h want deadbeef", wb_aludata); else n_pass++;
      n_checks++; if ({wb_rd, wb_regwrite} !== {5'd5, 1'b1}) $display("FAIL alu_wb_rd_rw got %0d %b want 5 1", wb_rd, wb_regwrite); else n_pass++;
      n_checks++; if (wb_loaddata !== m_loaddata) $display("FAIL alu_loaddata_hold got %h want %h", wb_loaddata, m_loaddata); else n_pass++;
      commit_model(m_ld_known, m_loaddata);
      stall_in = 1'b1;
      set_ex(1'b0, 1'b0, 3'b010, 32'h1234_5678, 32'h0, 5'd6, 1'b0, 1'b1, 1'b0);
      @(posedge clk); #1;
      n_checks++; if ({wb_aludata, wb_rd, wb_regwrite} !== {32'hDEAD_BEEF, 5'd5, 1'b1})
         $display("FAIL alu_stall_hold got %h %0d %b want deadbeef 5 1", wb_aludata, wb_rd, wb_regwrite); else n_pass++;
      stall_in = 1'b0;
      set_ex(1'b0, 1'b0, 3'b010, 32'hDEAD_BEEF, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      set_ex(1'b1, 1'b0, 3'b100, 32'h0000_0051, 32'h0, 5'd20, 1'b1, 1'b1, 1'b0);
      run_handshake(0, 0, 1'b0, 0, 32'h0000_C300);
      n_checks++; if (wb_loaddata !== 32'h0000_00C3) $display("FAIL b2b_first_loaddata got %h want 000000c3", wb_loaddata); else n_pass++;
      commit_model(1'b1, 32'h0000_00C3);
      set_ex(1'b1, 1'b0, 3'b001, 32'h0000_0062, 32'h0, 5'd21, 1'b1, 1'b1, 1'b0);
      run_handshake(0, 0, 1'b0, 0, 32'hF00D_0000);
      n_checks++; if (obs_first_req !== 1'b1) $display("FAIL b2b_immediate_issue got %b want 1", obs_first_req); else n_pass++;
      n_checks++; if (obs_stall !== 2) $display("FAIL b2b_stall_cycles got %0d want 2", obs_stall); else n_pass++;
      n_checks++; if ({wb_loaddata, wb_rd} !== {32'hFFFF_F00D, 5'd21})
         $display("FAIL b2b_second_wb got %h %0d want fffff00d 21", wb_loaddata, wb_rd); else n_pass++;
      commit_model(1'b1, 32'hFFFF_F00D);
   endtask

   task automatic test_random();
      logic [2:0]  ld_types [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      logic [2:0]  dt;
      logic [31:0] addr, sd, rdata, ld_exp, wd_exp, mask;
      logic [3:0]  st_exp;
      logic [3:0]  idx;
      int          kind, rdy, rv;
      bit          is_st;
      for (int i = 0; i < 16; i++) mem[i] = $urandom();
      for (int it = 0; it < 40; it++) begin
         kind  = int'($urandom_range(0, 2));   // 0 load, 1 store, 2 read+write (load)
         is_st = (kind == 1);
         dt    = is_st ? ld_types[$urandom_range(0, 2)] : ld_types[$urandom_range(0, 4)];
         addr  = 32'h0000_0100 + 32'($urandom_range(0, 63));
         idx   = addr[5:2];
         sd    = $urandom();
         rdy   = int'($urandom_range(0, 3));
         rv    = int'($urandom_range(0, 3));
         rdata = is_st ? $urandom() : mem[idx];
         set_ex(kind != 1, kind != 0, dt, addr, sd, 5'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()));
         st_exp = is_st ? exp_strb(dt, addr[1:0]) : 4'b0000;
         wd_exp = exp_wdata(dt, sd);
         ld_exp = exp_load(dt, addr[1:0], rdata);
         run_handshake(rdy, rv, 1'($urandom()), int'($urandom_range(0, 2)), rdata);
         n_checks++; if (obs_addr !== {addr[31:2], 2'b00}) $display("FAIL rnd%0d_addr got %h want %h", it, obs_addr, {addr[31:2], 2'b00}); else n_pass++;
         n_checks++; if (obs_strb !== st_exp) $display("FAIL rnd%0d_wstrb got %b want %b", it, obs_strb, st_exp); else n_pass++;
         if (is_st) begin
            n_checks++; if (obs_wdata !== wd_exp) $display("FAIL rnd%0d_wdata got %h want %h", it, obs_wdata, wd_exp); else n_pass++;
            for (int b = 0; b < 4; b++) begin
               if (st_exp[b]) begin
                  mask = 32'h0000_00FF << (8 * b);
                  mem[idx] = (mem[idx] & ~mask) | (wd_exp & mask);
               end
            end
         end else begin
            n_checks++; if (wb_loaddata !== ld_exp) $display("FAIL rnd%0d_loaddata got %h want %h", it, wb_loaddata, ld_exp); else n_pass++;
         end
         n_checks++; if (obs_req !== rdy + 1) $display("FAIL rnd%0d_req_cycles got %0d want %0d", it, obs_req, rdy + 1); else n_pass++;
         n_checks++; if (obs_stall !== rdy + rv + 2) $display("FAIL rnd%0d_stall_cycles got %0d want %0d", it, obs_stall, rdy + rv + 2); else n_pass++;
         n_checks++; if (obs_unstable + obs_bubble + obs_hold !== 0)
            $display("FAIL rnd%0d_inflight got unstable=%0d bubble=%0d hold=%0d want 0", it, obs_unstable, obs_bubble, obs_hold); else n_pass++;
         n_checks++; if ({wb_aludata, wb_rd, wb_regwrite, wb_memtoreg, wb_floatwb} !== {addr, ex_rd, ex_regwrite, ex_memtoreg, ex_floatwb})
            $display("FAIL rnd%0d_wb_capture got %h %0d %b%b%b want %h %0d %b%b%b", it, wb_aludata, wb_rd, wb_regwrite, wb_memtoreg,
                     wb_floatwb, addr, ex_rd, ex_regwrite, ex_memtoreg, ex_floatwb); else n_pass++;
         commit_model(!is_st, ld_exp);
      end
   endtask

   initial begin
      rst = 1'b1; stall_in = 1'b0; dm_ready = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
      set_ex(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      test_reset();
      test_lb_sign();
      test_sh_bubble();
      test_lhu_lw();
      test_stall_in_wait();
      test_reset_mid_op();
      test_alu_op();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory stage of the 5-stage RV32 core. It sits directly downstream of the EX/MEM pipeline register and consumes the ALU result, the store data and the control bits that register produces. For loads and stores it runs a req/ready plus rvalid handshake with the data-memory port, and it stalls the pipeline until the transaction completes. It aligns and strobes store data, aligns and sign/zero-extends load data, and registers the results into the MEM/WB register that feeds writeback.

Parameters:
XLEN, 32, data and address width; only 32 is supported.

Ports:
clk  in  1  core clock
rst  in  1  reset; synchronous, active-high
ex_aludata  in  32  ALU result from EX/MEM; this is the effective address for memory ops
ex_storedata  in  32  rs2 or frs2 value to store
ex_memread  in  1  load in MEM stage
ex_memwrite  in  1  store in MEM stage
ex_memtoreg  in  1  writeback selects load data
ex_rd  in  5  destination register
ex_regwrite  in  1  integer register write
ex_floatwb  in  1  FP register write (flw)
ex_datatype  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
stall_in  in  1  global stall from another stage (e.g. IF miss)
dm_req  out  1  memory request valid
dm_ready  in  1  memory accepts the request this cycle
dm_addr  out  32  word-aligned address ({ex_aludata[31:2],2'b00})
dm_wstrb  out  4  byte write strobes; 0 for loads
dm_wdata  out  32  lane-aligned store data
dm_rvalid  in  1  response (load data or write ack)
dm_rdata  in  32  load word
mem_stall  out  1  freeze IF..EX/MEM
wb_aludata  out  32  registered ALU result
wb_loaddata  out  32  registered, extended load value
wb_memtoreg  out  1  registered
wb_rd  out  5  registered
wb_regwrite  out  1  registered
wb_floatwb  out  1  registered

Behaviour:
- Memory op present: op = ex_memread | ex_memwrite. If both are set, the op is treated as a load.
- FSM states:
  - IDLE: op=1 drives dm_req=1 combinationally. dm_ready=1 goes to WAIT; otherwise go to REQ. op=0 stays in IDLE.
  - REQ: dm_req=1 with addr, strb and wdata held stable. dm_ready=1 goes to WAIT.
  - WAIT: dm_req=0. dm_rvalid=1 goes to DONE and latches the aligned load value into an internal holding register.
  - DONE: if stall_in=0, go to IDLE; otherwise remain in DONE and never reissue.
- dm_rvalid is never asserted in the same cycle as acceptance. Minimum op cost is 3 cycles: accept, respond, DONE.
- mem_stall = op & (state != DONE). It is 0 when no memory op is present.
- Store alignment:
  - SB: wstrb = 0001 << addr[1:0]; data byte replicated to all 4 lanes.
  - SH: wstrb = addr[1] ? 1100 : 0011; halfword replicated to both halves.
  - SW: wstrb = 1111.
  - addr[0] is ignored for H and addr[1:0] is ignored for W. No misalignment traps.
- Load extraction: the byte lane is selected by addr[1:0] and the half lane by addr[1]. B and H sign-extend; BU and HU zero-extend; W is passed through unchanged.
- MEM/WB register update, evaluated in priority order:
  - rst=1: every wb_* output is 0.
  - stall_in=1: hold all wb_* outputs.
  - mem_stall=1: insert a bubble. wb_regwrite=0 and wb_floatwb=0; other wb_* outputs hold.
  - Otherwise capture ex_* inputs. wb_loaddata takes the holding register when op=1, else holds.
- Reset:
  - FSM returns to IDLE, dm_req=0, holding register cleared.
  - A dm_rvalid arriving in IDLE or REQ is ignored, so a response left outstanding by a reset mid-op is dropped.
- Simultaneous events: stall_in=1 in WAIT does not block the transition to DONE. The response is captured and DONE then waits for stall_in to drop.
- Back-to-back ops: after DONE, EX/MEM advances. A new op seen in IDLE on the next cycle issues immediately.

Decomposition:
- Shared package core_pkg holds:
  - the datatype_e enum for funct3 (DT_B, DT_H, DT_W, DT_BU, DT_HU);
  - the lsu_state_e enum (IDLE, REQ, WAIT, DONE);
  - the XLEN constant.
- One combinational sub-module, lsu_align, produces store strobes and lanes and performs load extraction and extension. The FSM and the MEM/WB register live in mem_stage_lsu.

Test Plan:
1. LB sign-extension: ex_aludata=0x1003, LB, dm_rdata=0x80FF_0000, dm_ready=1 in the same cycle, rvalid one cycle later.
   - Response: dm_addr=0x1000, dm_wstrb=0000.
   - mem_stall high for 2 cycles.
   - After DONE: wb_loaddata=0xFFFF_FF80 with wb_regwrite and wb_memtoreg as input.
2. SH strobes and bubble: addr=0x2002, SH, storedata=0x0000_BEEF, dm_ready delayed 3 cycles.
   - Response: dm_req held 4 cycles with dm_wstrb=1100 and dm_wdata=0xBEEF_BEEF stable throughout.
   - wb_regwrite=0 bubbles while stalled.
3. LHU zero-extension and LW pass-through:
   - LHU at 0x10, rdata=0x1234_8001 -> wb_loaddata=0x0000_8001.
   - LW with floatwb=1 -> wb_loaddata=rdata and wb_floatwb=1.
4. stall_in during WAIT:
   - Response: rvalid captured, FSM stays in DONE while stall_in=1 with no second dm_req.
   - wb_* holds until stall_in drops, then captures.
5. Reset mid-op: rst asserted in WAIT, rvalid arrives the cycle after reset.
   - Response: state IDLE, all wb_*=0, mem_stall=0 when op=0, stale rvalid ignored.
6. Non-memory ALU op: op=0, ex_aludata=0xDEAD_BEEF, rd=5, regwrite=1.
   - Response: no dm_req, mem_stall=0, wb_aludata=0xDEAD_BEEF and wb_rd=5 captured next cycle.
